// File: rtl/pc_seq_ctrl_if.sv
// ID-stage control-transfer bundle between decode and the PC sequencer.
// slave = sequencer side, master = decode/driver side.
interface pc_seq_ctrl_if;
    logic        STALL_ID;
    logic        VALID_ID;
    logic        BRANCH_ID;
    logic        CALL_ID;
    logic        JMPL_ID;
    logic        COND_ID;
    logic        BA_ID;
    logic        ANNUL_ID;
    logic [31:0] TAG_IN;
    logic [31:0] JMPL_TARGET;
    logic        BI_ID;
    logic        FLUSH_IF;
    logic        REDIRECT;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic [1:0]  STATE;
    logic        DCTI_ERR;
    logic        MISALIGN;

    modport slave (
        input  STALL_ID, VALID_ID, BRANCH_ID, CALL_ID, JMPL_ID,
               COND_ID, BA_ID, ANNUL_ID, TAG_IN, JMPL_TARGET,
        output BI_ID, FLUSH_IF, REDIRECT, PC, NPC, STATE, DCTI_ERR, MISALIGN
    );

    modport master (
        output STALL_ID, VALID_ID, BRANCH_ID, CALL_ID, JMPL_ID,
               COND_ID, BA_ID, ANNUL_ID, TAG_IN, JMPL_TARGET,
        input  BI_ID, FLUSH_IF, REDIRECT, PC, NPC, STATE, DCTI_ERR, MISALIGN
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC/nPC sequencer with delayed-branch control: redirects fetch on taken
// Bicc/CALL/JMPL, annuls delay slots, suppresses CTIs sitting in a slot.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] RESET_NPC = 32'h0000_0004
) (
    input  logic         CLK,
    input  logic         RST_N,
    pc_seq_ctrl_if.slave bus
);
    localparam logic [1:0] ST_SEQ   = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_ANNUL = 2'd2;

    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_en;
    logic        w_bi;
    logic        w_call;
    logic        w_jmpl;
    logic        w_taken;
    logic        w_flush;
    logic        w_cti;
    logic [31:0] w_target;

    // RST_N gates every pulse so nothing leaks out while reset is held.
    assign w_en    = RST_N & bus.VALID_ID & (r_state == ST_SEQ) & ~bus.STALL_ID;
    assign w_bi    = w_en & bus.BRANCH_ID & bus.COND_ID;
    assign w_call  = w_en & bus.CALL_ID;
    assign w_jmpl  = w_en & bus.JMPL_ID;
    assign w_taken = w_bi | w_call | w_jmpl;
    assign w_flush = w_en & bus.BRANCH_ID & bus.ANNUL_ID & (~bus.COND_ID | bus.BA_ID);
    assign w_cti   = w_en & (bus.BRANCH_ID | bus.CALL_ID | bus.JMPL_ID);

    // JMPL targets are word-aligned by force; misalignment is only flagged.
    assign w_target = (w_bi | w_call) ? bus.TAG_IN : {bus.JMPL_TARGET[31:2], 2'b00};

    always_comb begin
        w_state_nxt = ST_SEQ;
        if (r_state == ST_SEQ) begin
            if (w_flush)
                w_state_nxt = ST_ANNUL;
            else if (w_cti)
                w_state_nxt = ST_DELAY;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc    <= RESET_PC;
            r_npc   <= RESET_NPC;
            r_state <= ST_SEQ;
        end else if (!bus.STALL_ID) begin
            r_state <= w_state_nxt;
            if (w_taken) begin
                r_pc  <= w_target;
                r_npc <= w_target + 32'd4;
            end else begin
                r_pc  <= r_npc;
                r_npc <= r_npc + 32'd4;
            end
        end
    end

    assign bus.BI_ID    = w_bi;
    assign bus.FLUSH_IF = w_flush;
    assign bus.REDIRECT = w_taken;
    assign bus.PC       = r_pc;
    assign bus.NPC      = r_npc;
    assign bus.STATE    = r_state;
    assign bus.MISALIGN = w_jmpl & (bus.JMPL_TARGET[1:0] != 2'b00);
    assign bus.DCTI_ERR = RST_N & (r_state == ST_DELAY) & bus.VALID_ID & ~bus.STALL_ID
                        & (bus.BRANCH_ID | bus.CALL_ID | bus.JMPL_ID);
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: hand-computed PC/NPC/STATE and pulse values.
module tb_pc_seq_ctrl;
    logic CLK;
    logic RST_N;
    int   n_chk;
    int   n_bad;

    pc_seq_ctrl_if bus();

    pc_seq_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .RESET_NPC (32'h0000_0004)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one edge, land 1ns past it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        bus.STALL_ID    = 1'b0;
        bus.VALID_ID    = 1'b1;
        bus.BRANCH_ID   = 1'b0;
        bus.CALL_ID     = 1'b0;
        bus.JMPL_ID     = 1'b0;
        bus.COND_ID     = 1'b0;
        bus.BA_ID       = 1'b0;
        bus.ANNUL_ID    = 1'b0;
        bus.TAG_IN      = 32'h0;
        bus.JMPL_TARGET = 32'h0;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                            input logic [1:0] st);
        chk({tag, ".pc"},  bus.PC,  pc);
        chk({tag, ".npc"}, bus.NPC, npc);
        chk({tag, ".st"},  {30'd0, bus.STATE}, {30'd0, st});
    endtask

    task automatic chk_pulses(input string tag, input logic bi, input logic fl,
                              input logic rd, input logic de, input logic ma);
        chk({tag, ".pulses"},
            {27'd0, bus.BI_ID, bus.FLUSH_IF, bus.REDIRECT, bus.DCTI_ERR, bus.MISALIGN},
            {27'd0, bi, fl, rd, de, ma});
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        clr();
        RST_N = 1'b0;

        // reset: CTI inputs asserted, yet all pulses held low
        bus.BRANCH_ID = 1'b1; bus.COND_ID = 1'b1; bus.JMPL_ID = 1'b1;
        bus.JMPL_TARGET = 32'h3;
        #12;
        chk_regs("rst", 32'h0, 32'h4, 2'd0);
        chk_pulses("rst", 0, 0, 0, 0, 0);
        clr();
        #1 RST_N = 1'b1;
        #1;
        chk_regs("rel", 32'h0, 32'h4, 2'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_regs($sformatf("seq%0d", k), 32'(4*k), 32'(4*k+4), 2'd0);
            chk_pulses($sformatf("seq%0d", k), 0, 0, 0, 0, 0);
        end

        // CALL to 0xFC, delay slot falls on 0x100
        bus.CALL_ID = 1'b1; bus.TAG_IN = 32'hFC;
        #1 chk_pulses("call", 0, 0, 1, 0, 0);
        step(); clr();
        chk_regs("call", 32'hFC, 32'h100, 2'd1);
        step();
        chk_regs("slot", 32'h100, 32'h104, 2'd0);

        // taken Bicc a=0
        bus.BRANCH_ID = 1'b1; bus.COND_ID = 1'b1; bus.TAG_IN = 32'h200;
        #1 chk_pulses("bt", 1, 0, 1, 0, 0);
        step(); clr();
        chk_regs("bt", 32'h200, 32'h204, 2'd1);
        step();
        chk_regs("bt2", 32'h204, 32'h208, 2'd0);

        // untaken Bicc a=1
        bus.BRANCH_ID = 1'b1; bus.ANNUL_ID = 1'b1; bus.TAG_IN = 32'h900;
        #1 chk_pulses("bn_a", 0, 1, 0, 0, 0);
        step(); clr();
        chk_regs("bn_a", 32'h208, 32'h20C, 2'd2);
        // in ANNUL, a CTI is ignored and is not a DCTI error
        bus.BRANCH_ID = 1'b1; bus.COND_ID = 1'b1; bus.TAG_IN = 32'h900;
        #1 chk_pulses("annul_ign", 0, 0, 0, 0, 0);
        step(); clr();
        chk_regs("annul_ign", 32'h20C, 32'h210, 2'd0);

        // BA,a: flush and redirect together
        bus.BRANCH_ID = 1'b1; bus.COND_ID = 1'b1; bus.BA_ID = 1'b1; bus.ANNUL_ID = 1'b1;
        bus.TAG_IN = 32'h300;
        #1 chk_pulses("ba_a", 1, 1, 1, 0, 0);
        step(); clr();
        chk_regs("ba_a", 32'h300, 32'h304, 2'd2);
        step();
        chk_regs("ba_a2", 32'h304, 32'h308, 2'd0);

        // taken conditional a=1 keeps its slot
        bus.BRANCH_ID = 1'b1; bus.COND_ID = 1'b1; bus.ANNUL_ID = 1'b1; bus.TAG_IN = 32'h400;
        #1 chk_pulses("bt_a", 1, 0, 1, 0, 0);
        step(); clr();
        chk_regs("bt_a", 32'h400, 32'h404, 2'd1);
        step();
        chk_regs("bt_a2", 32'h404, 32'h408, 2'd0);

        // misaligned JMPL, then CALL in its delay slot
        bus.JMPL_ID = 1'b1; bus.JMPL_TARGET = 32'h0000_1003; bus.TAG_IN = 32'h7000;
        #1 chk_pulses("jmpl", 0, 0, 1, 0, 1);
        step(); clr();
        chk_regs("jmpl", 32'h1000, 32'h1004, 2'd1);
        bus.CALL_ID = 1'b1; bus.TAG_IN = 32'h5000;
        #1 chk_pulses("dcti", 0, 0, 0, 1, 0);
        step(); clr();
        chk_regs("dcti", 32'h1004, 32'h1008, 2'd0);

        // CALL held under a 3-cycle stall
        bus.CALL_ID = 1'b1; bus.TAG_IN = 32'h2000; bus.STALL_ID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk_pulses($sformatf("stall%0d", k), 0, 0, 0, 0, 0);
            step();
            chk_regs($sformatf("stall%0d", k), 32'h1004, 32'h1008, 2'd0);
        end
        bus.STALL_ID = 1'b0;
        #1 chk_pulses("unstall", 0, 0, 1, 0, 0);
        step(); clr();
        chk_regs("unstall", 32'h2000, 32'h2004, 2'd1);
        // stall in DELAY holds DELAY
        bus.STALL_ID = 1'b1;
        step();
        chk_regs("stall_dly", 32'h2000, 32'h2004, 2'd1);
        bus.STALL_ID = 1'b0;
        step();
        chk_regs("stall_dly2", 32'h2004, 32'h2008, 2'd0);

        // wrap at the top of the address space
        bus.CALL_ID = 1'b1; bus.TAG_IN = 32'hFFFF_FFF8;
        step(); clr();
        chk_regs("wrap0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'd1);
        step();
        chk_regs("wrap1", 32'hFFFF_FFFC, 32'h0, 2'd0);
        step();
        chk_regs("wrap2", 32'h0, 32'h4, 2'd0);

        // async reset mid-cycle while in DELAY
        bus.CALL_ID = 1'b1; bus.TAG_IN = 32'h40;
        step(); clr();
        chk_regs("pre_rst", 32'h40, 32'h44, 2'd1);
        bus.CALL_ID = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        chk_regs("async_rst", 32'h0, 32'h4, 2'd0);
        chk_pulses("async_rst", 0, 0, 0, 0, 0);
        clr();
        #1 RST_N = 1'b1;
        step();
        chk_regs("post_rst", 32'h4, 32'h8, 2'd0);
        chk_pulses("post_rst", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
